bus_xfer_scheduler: RTL and testbench

- Shared-bus controller for a small register file whose registers share one transfer bus; each register has an out-enable (h) and a load-enable (c).
- Serves two requesters, each issuing a move or swap between two registers, with round-robin arbitration.
- Sequences each operation over the bus one transfer per cycle, using the highest-index register as the swap scratch register.
- Sits between requester logic and the register-file enables; it generalises the fixed three-register swap controller.

---
 rtl/bus_xfer_scheduler.sv | 124 ++++++++++++
 tb/tb_bus_xfer_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_scheduler.sv
// rtl/bus_xfer_scheduler.sv - round-robin shared-bus move/swap scheduler; optional BUS_XFER_COUNT_EN adds xfer_cnt
module bus_xfer_scheduler #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic                op0,
  input  logic [IDX_W-1:0]    src0,
  input  logic [IDX_W-1:0]    dst0,
  input  logic                op1,
  input  logic [IDX_W-1:0]    src1,
  input  logic [IDX_W-1:0]    dst1,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic [NUM_REGS-1:0] h,
  output logic [NUM_REGS-1:0] c,
  output logic                busy
`ifdef BUS_XFER_COUNT_EN
  ,
  output logic [7:0]          xfer_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, DONE, ERR} state_t;

  localparam logic [IDX_W-1:0] TMP = IDX_W'(NUM_REGS - 1);

  state_t           state, state_nx;
  logic             win_q, last_q, op_q;
  logic [IDX_W-1:0] src_q, dst_q;

  logic             pick, pick_op, legal;
  logic [IDX_W-1:0] pick_src, pick_dst;

  function automatic logic [NUM_REGS-1:0] oh(input logic [IDX_W-1:0] i);
    oh = NUM_REGS'(1) << i;
  endfunction

  // On a tie the requester not served last wins.
  always_comb begin
    pick     = (req == 2'b11) ? ~last_q : req[1];
    pick_op  = pick ? op1  : op0;
    pick_src = pick ? src1 : src0;
    pick_dst = pick ? dst1 : dst0;
    legal    = (pick_src != pick_dst) && (pick_src != TMP) && (pick_dst != TMP) &&
               (int'(pick_src) < NUM_REGS) && (int'(pick_dst) < NUM_REGS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      win_q  <= 1'b0;
      last_q <= 1'b1;
      op_q   <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req != 2'b00) begin
        win_q  <= pick;
        last_q <= pick;
        op_q   <= pick_op;
        src_q  <= pick_src;
        dst_q  <= pick_dst;
      end
    end
  end

  always_comb begin
    state_nx = state;
    h        = '0;
    c        = '0;
    gnt      = 2'b00;
    done     = 2'b00;
    err      = 2'b00;
    case (state)
      IDLE: if (req != 2'b00) state_nx = legal ? T1 : ERR;
      T1: begin
        h           = oh(src_q);
        c           = op_q ? oh(TMP) : oh(dst_q);
        gnt[win_q]  = 1'b1;
        state_nx    = op_q ? T2 : DONE;
      end
      T2: begin
        h          = oh(dst_q);
        c          = oh(src_q);
        gnt[win_q] = 1'b1;
        state_nx   = T3;
      end
      T3: begin
        h          = oh(TMP);
        c          = oh(dst_q);
        gnt[win_q] = 1'b1;
        state_nx   = DONE;
      end
      DONE: begin
        gnt[win_q]  = 1'b1;
        done[win_q] = 1'b1;
        state_nx    = IDLE;
      end
      ERR: begin
        err[win_q] = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef BUS_XFER_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt <= 8'd0;
    end else if (state == DONE && xfer_cnt != 8'hff) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_xfer_scheduler.sv
// tb/tb_bus_xfer_scheduler.sv - self-checking bench for bus_xfer_scheduler with a register-file model on the bus
module tb_bus_xfer_scheduler;
  localparam int NR  = 4;
  localparam int TMP = 3;

  logic       clk = 1'b0, rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic       op0 = 1'b0, op1 = 1'b0;
  logic [1:0] src0 = '0, dst0 = '0, src1 = '0, dst1 = '0;
  logic [1:0] gnt, done, err;
  logic [3:0] h, c;
  logic       busy;
`ifdef BUS_XFER_COUNT_EN
  logic [7:0] xfer_cnt;
`endif

  bus_xfer_scheduler #(.NUM_REGS(NR), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op0(op0), .src0(src0), .dst0(dst0),
    .op1(op1), .src1(src1), .dst1(dst1),
    .gnt(gnt), .done(done), .err(err), .h(h), .c(c), .busy(busy)
`ifdef BUS_XFER_COUNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Register file driven by the bus enables, plus a reference copy updated by whole operations.
  logic [7:0] rf[4], rf_init[4], mrf[4];
  logic       rf_load = 1'b0;

  function automatic int idx_of(input logic [3:0] v);
    idx_of = -1;
    for (int i = 0; i < 4; i++) if (v[i]) idx_of = i;
  endfunction

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
    end else if (h != 4'b0 && c != 4'b0) begin
      rf[idx_of(c)] <= rf[idx_of(h)];
    end
  end

  function automatic bit is_legal(input logic [1:0] s, input logic [1:0] d);
    return (s != d) && (int'(s) != TMP) && (int'(d) != TMP) && (int'(s) < NR) && (int'(d) < NR);
  endfunction

  function automatic void model_op(input logic op, input logic [1:0] s, input logic [1:0] d);
    logic [7:0] a, b;
    if (!is_legal(s, d)) return;
    a = mrf[s];
    b = mrf[d];
    if (op) begin
      mrf[TMP] = a;
      mrf[s]   = b;
      mrf[d]   = a;
    end else begin
      mrf[d] = a;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_rf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] x, input logic [7:0] d);
    rf_init[0] = a; rf_init[1] = b; rf_init[2] = x; rf_init[3] = d;
    rf_load = 1'b1;
    @(negedge clk);
    rf_load = 1'b0;
  endtask

  task automatic set_req(input int r, input logic op, input logic [1:0] s, input logic [1:0] d);
    if (r == 0) begin op0 = op; src0 = s; dst0 = d; end
    else        begin op1 = op; src1 = s; dst1 = d; end
    req[r] = 1'b1;
  endtask

  task automatic sync_model();
    for (int i = 0; i < 4; i++) mrf[i] = rf[i];
  endtask

  task automatic cmp_rf(input string name);
    for (int i = 0; i < 4; i++) chk(name, {24'd0, rf[i]}, {24'd0, mrf[i]});
  endtask

  // Single-requester operation, called at a negedge with the DUT idle.
  task automatic do_req(input int r, input logic op, input logic [1:0] s, input logic [1:0] d,
                        input int exp_lat, input bit exp_err);
    logic [3:0] eh, ec;
    bit seen;
    int k;
    sync_model();
    model_op(op, s, d);
    set_req(r, op, s, d);
    seen = 0;
    k = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      eh = 4'b0;
      ec = 4'b0;
      if (!exp_err) begin
        if (!op && k == 1) begin eh = 4'b0001 << s; ec = 4'b0001 << d; end
        if (op && k == 1)  begin eh = 4'b0001 << s; ec = 4'b1000; end
        if (op && k == 2)  begin eh = 4'b0001 << d; ec = 4'b0001 << s; end
        if (op && k == 3)  begin eh = 4'b1000;      ec = 4'b0001 << d; end
      end
      chk("bus_h", {28'd0, h}, {28'd0, eh});
      chk("bus_c", {28'd0, c}, {28'd0, ec});
      if (done != 2'b00 || err != 2'b00) begin
        seen = 1;
        chk("latency", k, exp_lat);
        chk("done_pulse", {30'd0, done}, exp_err ? 32'd0 : (32'd1 << r));
        chk("err_pulse", {30'd0, err}, exp_err ? (32'd1 << r) : 32'd0);
        chk("gnt_end", {30'd0, gnt}, exp_err ? 32'd0 : (32'd1 << r));
        req[r] = 1'b0;
      end else begin
        chk("gnt_op", {30'd0, gnt}, 32'd1 << r);
      end
    end
    if (!seen) begin
      chk("op_timeout", 32'd0, 32'd1);
      req = 2'b00;
    end
    @(negedge clk);
    chk("idle_after", {31'd0, busy}, 32'd0);
    cmp_rf("regfile");
  endtask

  typedef struct {
    int         r;
    logic       op;
    logic [1:0] s;
    logic [1:0] d;
    int         lat;
    bit         e;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int nd, k, first_gnt;
    int order[3];
    bit after_done;
    logic op;
    logic [1:0] s, d;
    int r;

    tbl[0] = '{0, 1'b0, 2'd1, 2'd2, 2, 1'b0};
    tbl[1] = '{1, 1'b1, 2'd0, 2'd2, 4, 1'b0};
    tbl[2] = '{0, 1'b0, 2'd1, 2'd1, 1, 1'b1};
    tbl[3] = '{0, 1'b0, 2'd1, 2'd3, 1, 1'b1};
    tbl[4] = '{1, 1'b1, 2'd3, 2'd0, 1, 1'b1};
    tbl[5] = '{1, 1'b0, 2'd2, 2'd0, 2, 1'b0};
    tbl[6] = '{0, 1'b1, 2'd2, 2'd1, 4, 1'b0};
    tbl[7] = '{1, 1'b1, 2'd1, 2'd1, 1, 1'b1};

    #3;
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_done", {30'd0, done}, 0);
    chk("rst_err", {30'd0, err}, 0);
    chk("rst_h", {28'd0, h}, 0);
    chk("rst_c", {28'd0, c}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      load_rf(8'd5, 8'd7, 8'd9, 8'd0);
      do_req(tbl[i].r, tbl[i].op, tbl[i].s, tbl[i].d, tbl[i].lat, tbl[i].e);
    end

    // Tie with both requests held: expect 0,1,0 with an idle cycle between operations.
    load_rf(8'd10, 8'd20, 8'd30, 8'd40);
    sync_model();
    model_op(1'b1, 2'd0, 2'd1);
    model_op(1'b1, 2'd1, 2'd2);
    model_op(1'b1, 2'd0, 2'd1);
    op0 = 1'b1; src0 = 2'd0; dst0 = 2'd1;
    op1 = 1'b1; src1 = 2'd1; dst1 = 2'd2;
    req = 2'b11;
    nd = 0; k = 0; after_done = 0;
    while (nd < 3 && k < 40) begin
      @(negedge clk);
      k++;
      chk("tie_no_overlap", {31'd0, gnt == 2'b11}, 0);
      if (after_done) begin
        chk("tie_idle_gap", {31'd0, busy}, 0);
        after_done = 0;
      end
      if (done != 2'b00) begin
        order[nd] = int'(done[1]);
        nd++;
        after_done = 1;
        if (nd == 3) req = 2'b00;
      end
    end
    chk("tie_count", nd, 3);
    chk("tie_order0", order[0], 0);
    chk("tie_order1", order[1], 1);
    chk("tie_order2", order[2], 0);
    @(negedge clk);
    chk("tie_idle_end", {31'd0, busy}, 0);
    cmp_rf("tie_regfile");

    // An illegal request still consumes requester 0's turn.
    do_req(0, 1'b0, 2'd1, 2'd1, 1, 1'b1);
    op0 = 1'b0; src0 = 2'd0; dst0 = 2'd1;
    op1 = 1'b0; src1 = 2'd2; dst1 = 2'd0;
    req = 2'b11;
    @(negedge clk);
    first_gnt = int'(gnt);
    chk("rr_after_err", first_gnt, 2);
    k = 0;
    while (done == 2'b00 && k < 10) begin @(negedge clk); k++; end
    chk("rr_done", {30'd0, done}, 2);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);

    // Reset asserted during T2 of a swap.
    load_rf(8'd1, 8'd2, 8'd3, 8'd4);
    set_req(0, 1'b1, 2'd0, 2'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_h", {28'd0, h}, 4'b0010);
    #2 rst = 1'b0;
    #1;
    chk("abort_h", {28'd0, h}, 0);
    chk("abort_c", {28'd0, c}, 0);
    chk("abort_gnt", {30'd0, gnt}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, busy}, 0);
      chk("post_rst_done", {30'd0, done}, 0);
    end

    // Randomized single-requester operations against the model.
    for (int i = 0; i < 40; i++) begin
      load_rf(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      r  = int'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      d  = 2'($urandom_range(0, 3));
      do_req(r, op, s, d, !is_legal(s, d) ? 1 : (op ? 4 : 2), !is_legal(s, d));
    end

`ifdef BUS_XFER_COUNT_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("cnt_reset", {24'd0, xfer_cnt}, 0);
    load_rf(8'd1, 8'd2, 8'd3, 8'd4);
    do_req(0, 1'b0, 2'd0, 2'd1, 2, 1'b0);
    do_req(1, 1'b0, 2'd1, 2'd2, 2, 1'b0);
    do_req(0, 1'b0, 2'd0, 2'd3, 1, 1'b1);
    do_req(1, 1'b0, 2'd2, 2'd0, 2, 1'b0);
    chk("cnt_three", {24'd0, xfer_cnt}, 3);
    for (int i = 0; i < 260; i++) do_req(i % 2, 1'b0, 2'd0, 2'd1, 2, 1'b0);
    chk("cnt_saturate", {24'd0, xfer_cnt}, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
